// File: rtl/sel_arb2.sv
// sel_arb2: two-source burst arbiter with a registered output slot.
// Sources alternate on contention; one grant covers at most BURST beats.
module sel_arb2 #(
   parameter int DW    = 8,
   parameter int BURST = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] a_data,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [DW-1:0] b_data,
   input  logic          b_valid,
   output logic          b_ready,
   output logic [DW-1:0] y_data,
   output logic          y_valid,
   input  logic          y_ready,
   output logic [1:0]    s
);
   typedef enum logic [1:0] {IDLE = 2'b00, GNT_A = 2'b01, GNT_B = 2'b10} state_t;
   state_t        state_q, state_d;
   logic          lsp_q, lsp_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [DW-1:0] y_data_q, y_data_d;
   logic          y_valid_q, y_valid_d;
   logic          slot_free, cur_valid, xfer, grant_end;

   // last_b high means B was served last, so A wins a tie
   function automatic state_t arb(input logic av, input logic bv, input logic last_b);
      return (av && bv) ? (last_b ? GNT_A : GNT_B) : av ? GNT_A : bv ? GNT_B : IDLE;
   endfunction

   assign slot_free = !y_valid_q || y_ready;
   assign a_ready   = state_q == GNT_A && slot_free;
   assign b_ready   = state_q == GNT_B && slot_free;
   assign cur_valid = state_q == GNT_A ? a_valid : b_valid;
   assign xfer      = (a_valid && a_ready) || (b_valid && b_ready);
   assign grant_end = state_q != IDLE && (!cur_valid || (xfer && cnt_q == 4'(BURST - 1)));
   assign y_data    = y_data_q;
   assign y_valid   = y_valid_q;
   assign s         = state_q;

   always_comb begin
      state_d   = state_q == IDLE ? arb(a_valid, b_valid, lsp_q)
                : grant_end       ? arb(a_valid, b_valid, state_q == GNT_B) : state_q;
      lsp_d     = grant_end ? state_q == GNT_B : lsp_q;
      cnt_d     = (state_q == IDLE || grant_end) ? 4'd0 : cnt_q + 4'(xfer);
      y_valid_d = xfer || (y_valid_q && !y_ready);
      y_data_d  = xfer ? (state_q == GNT_A ? a_data : b_data) : y_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lsp_q     <= 1'b1;
         cnt_q     <= '0;
         y_data_q  <= '0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lsp_q     <= lsp_d;
         cnt_q     <= cnt_d;
         y_data_q  <= y_data_d;
         y_valid_q <= y_valid_d;
      end
   end
endmodule

// File: tb/tb_sel_arb2.sv
// tb_sel_arb2: directed scenario tasks plus an ordering soak for sel_arb2.
module tb_sel_arb2;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [7:0] a_data = '0, b_data = '0, y_data;
   logic       a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
   logic       a_ready, b_ready, y_valid;
   logic [1:0] s;
   int         n_cmp = 0, n_bad = 0;

   sel_arb2 #(.DW(8), .BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .s(s)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0; a_data = '0; b_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
      #3;
      n_cmp++; if (s !== 2'b00) begin n_bad++; $display("FAIL reset_s: got %b want 00", s); end
      n_cmp++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL reset_y_valid: got %b want 0", y_valid); end
      n_cmp++; if (y_data !== 8'h00) begin n_bad++; $display("FAIL reset_y_data: got %h want 00", y_data); end
      n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready}); end
      do_reset();
   endtask

   task automatic test_a_only();
      do_reset();
      a_valid = 1'b1; a_data = 8'h11; y_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (s !== 2'b01) begin n_bad++; $display("FAIL a_only_grant: got %b want 01", s); end
      n_cmp++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL a_only_first_valid: got %b want 0", y_valid); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_cmp++; if ({y_valid, y_data} !== {1'b1, 8'(8'h11 + i)}) begin n_bad++; $display("FAIL a_only_beat%0d: got %b/%h want 1/%h", i, y_valid, y_data, 8'(8'h11 + i)); end
         n_cmp++; if (s !== 2'b01) begin n_bad++; $display("FAIL a_only_s%0d: got %b want 01", i, s); end
         a_data = 8'(8'h12 + i);
      end
      a_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if ({s, y_valid} !== 3'b000) begin n_bad++; $display("FAIL a_only_idle: got %b want 000", {s, y_valid}); end
   endtask

   task automatic test_alternate();
      int idx;
      logic src_b;
      logic [7:0] exp;
      do_reset();
      a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA0; b_data = 8'hB0; y_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (s !== 2'b01) begin n_bad++; $display("FAIL alt_first_grant: got %b want 01", s); end
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         src_b = 1'((i / 4) % 2);
         idx   = (i / 8) * 4 + i % 4;
         exp   = src_b ? 8'(8'hB0 + idx) : 8'(8'hA0 + idx);
         n_cmp++; if ({y_valid, y_data} !== {1'b1, exp}) begin n_bad++; $display("FAIL alt_beat%0d: got %b/%h want 1/%h", i, y_valid, y_data, exp); end
         n_cmp++; if (s !== ((((i + 1) / 4) % 2) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL alt_s%0d: got %b", i, s); end
         if (src_b) b_data = 8'(8'hB0 + idx + 1);
         else       a_data = 8'(8'hA0 + idx + 1);
      end
   endtask

   task automatic test_stall();
      do_reset();
      a_valid = 1'b1; a_data = 8'h51; y_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if ({y_valid, y_data} !== 9'h151) begin n_bad++; $display("FAIL stall_first: got %b/%h want 1/51", y_valid, y_data); end
      a_data = 8'h52; y_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready%0d: got %b want 0", i, a_ready); end
         @(posedge clk); #1;
         n_cmp++; if ({y_valid, y_data, s} !== {9'h151, 2'b01}) begin n_bad++; $display("FAIL stall_hold%0d: got %b/%h/%b want 1/51/01", i, y_valid, y_data, s); end
      end
      y_ready = 1'b1;
      #1;
      n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b want 1", a_ready); end
      @(posedge clk); #1;
      n_cmp++; if ({y_valid, y_data} !== 9'h152) begin n_bad++; $display("FAIL stall_release: got %b/%h want 1/52", y_valid, y_data); end
      a_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (y_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_dup: got %b want 0", y_valid); end
   endtask

   task automatic test_b_drop();
      do_reset();
      b_valid = 1'b1; b_data = 8'h61; y_ready = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b1; a_data = 8'h71;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_cmp++; if ({s, y_data} !== {2'b10, 8'(8'h61 + i)}) begin n_bad++; $display("FAIL bdrop_beat%0d: got %b/%h want 10/%h", i, s, y_data, 8'(8'h61 + i)); end
         b_data = 8'(8'h62 + i);
      end
      b_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if ({s, y_valid} !== 3'b010) begin n_bad++; $display("FAIL bdrop_switch: got %b want 010", {s, y_valid}); end
      @(posedge clk); #1;
      n_cmp++; if ({y_valid, y_data} !== 9'h171) begin n_bad++; $display("FAIL bdrop_a_beat: got %b/%h want 1/71", y_valid, y_data); end
      a_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      b_valid = 1'b1; b_data = 8'h81; y_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if ({s, y_valid, y_data} !== {2'b10, 9'h181}) begin n_bad++; $display("FAIL rmid_pre: got %b/%b/%h want 10/1/81", s, y_valid, y_data); end
      y_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({s, y_valid, y_data} !== 11'h000) begin n_bad++; $display("FAIL rmid_async: got %b/%b/%h want 00/0/00", s, y_valid, y_data); end
      a_valid = 1'b1; a_data = 8'h91; y_ready = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (s !== 2'b01) begin n_bad++; $display("FAIL rmid_a_first: got %b want 01", s); end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_soak();
      logic [7:0] q[$];
      logic [6:0] a_cnt = '0, b_cnt = '0;
      logic       acc_a, acc_b;
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         a_valid = 1'($urandom_range(0, 3) != 0);
         b_valid = 1'($urandom_range(0, 3) != 0);
         y_ready = 1'($urandom_range(0, 2) != 0);
         if (c > 9950) begin a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1; end
         a_data = {1'b0, a_cnt};
         b_data = {1'b1, b_cnt};
         #1;
         n_cmp++; if (a_ready && b_ready) begin n_bad++; $display("FAIL soak_both_ready cycle %0d: got 11 want not both", c); end
         if (y_valid && y_ready) begin
            n_cmp++;
            if (q.size() == 0) begin n_bad++; $display("FAIL soak_extra cycle %0d: got %h want none", c, y_data); end
            else begin
               if (y_data !== q[0]) begin n_bad++; $display("FAIL soak_order cycle %0d: got %h want %h", c, y_data, q[0]); end
               void'(q.pop_front());
            end
         end
         acc_a = a_valid && a_ready;
         acc_b = b_valid && b_ready;
         if (acc_a) q.push_back(a_data);
         if (acc_b) q.push_back(b_data);
         @(posedge clk); #1;
         if (acc_a) a_cnt++;
         if (acc_b) b_cnt++;
      end
      n_cmp++; if (q.size() != 0 || y_valid !== 1'b0) begin n_bad++; $display("FAIL soak_drain: got %0d pending, y_valid %b want 0/0", q.size(), y_valid); end
   endtask

   initial begin
      test_reset();
      test_a_only();
      test_alternate();
      test_stall();
      test_b_drop();
      test_reset_mid();
      test_soak();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sel_arb2.md
SEL_ARB2 -- requirements
Module: sel_arb2

Interface
REQ-001 Parameter DW, default 8, data width of every data port.
REQ-002 Parameter BURST, default 4, maximum consecutive beats per grant; legal range 1..15.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port a_data, input, DW, source A beat.
REQ-006 Port a_valid, input, 1, source A beat present.
REQ-007 Port a_ready, output, 1, source A beat accepted this cycle when high together with a_valid.
REQ-008 Port b_data, input, DW, source B beat.
REQ-009 Port b_valid, input, 1, source B beat present.
REQ-010 Port b_ready, output, 1, source B beat accepted this cycle when high together with b_valid.
REQ-011 Port y_data, output, DW, registered output beat.
REQ-012 Port y_valid, output, 1, y_data holds a beat.
REQ-013 Port y_ready, input, 1, downstream accepts y_data this cycle.
REQ-014 Port s, output, 2, registered select: 01 = A granted, 10 = B granted, 00 = idle; s[0] drives a downstream 2:1 select, where 1 picks A.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, GNT_A and GNT_B; s SHALL be 00, 01 and 10 respectively.
REQ-016 A last-served pointer (lsp) SHALL record the most recently granted source.
REQ-017 The arbitration rule SHALL be: only one valid, grant it; both valid, grant the source other than lsp; neither valid, go to IDLE.
REQ-018 In IDLE, the arbitration rule SHALL be evaluated every cycle, and a_ready and b_ready SHALL be 0.
REQ-019 Output slot free SHALL be defined as (!y_valid || y_ready).
REQ-020 a_ready SHALL equal (state==GNT_A && slot free), and b_ready SHALL equal (state==GNT_B && slot free); both SHALL never be high in the same cycle.
REQ-021 On a transfer (valid && ready of the granted source), y_data SHALL load the granted data, y_valid SHALL go to 1, and the beat counter SHALL increment.
REQ-022 When y_valid && y_ready and no transfer occurs, y_valid SHALL go to 0.
REQ-023 While y_valid && !y_ready, y_data SHALL be held stable.
REQ-024 The beat counter SHALL be 4 bits wide and SHALL clear on every entry into a grant state.
REQ-025 A grant SHALL end at the edge where the BURST-th beat transfers, or at any edge where the granted source's valid is 0.
REQ-026 On grant end, lsp SHALL update to the current source, the arbitration rule SHALL select the next state directly with no idle cycle, and re-granting the same source SHALL be allowed when the other source is not valid.
REQ-027 While the granted source's valid is high, the grant SHALL not be revoked by the other source's request before BURST beats.
REQ-028 Latency SHALL be: request seen in IDLE at edge N, grant at N, first ready in cycle N+1, and y_valid from edge N+1 when the slot is free.
REQ-029 If a source drops valid in the same edge as its BURST-th transfer, the BURST rule SHALL apply, with lsp updated as in REQ-026.
REQ-030 No beat SHALL be lost or duplicated under any y_ready pattern.

Reset
REQ-031 While rst_n is 0, the outputs SHALL be: state IDLE, s=00, y_valid=0, y_data=0, counter=0, lsp=B (so A wins the first contention), a_ready=0 and b_ready=0.
REQ-032 Assertion of rst_n mid-operation SHALL take effect immediately, discarding any held y_data beat.
REQ-033 After deassertion of rst_n, the first arbitration SHALL occur at the first rising clk edge.

Verification
REQ-034 Reset, then a_valid=1 only, y_ready=1, a_data=0x11,0x12,...: s=01 after 1 edge; y_data 0x11.. appears 1 cycle after each accept; at most 4 beats per grant, re-grant A with s staying 01.
REQ-035 Both valid from reset, y_ready=1: 4 beats of A, then 4 of B, alternating, with no bubble cycle on y_valid between grants.
REQ-036 Under a grant of A, hold y_ready=0 for 5 cycles: a_ready=0, y_data stable, y_valid=1; on release, the beat transfers once with no duplicate.
REQ-037 b_valid drops after 2 beats while a_valid=1: the grant switches to A on that edge, and lsp=B.
REQ-038 Pulse rst_n low while y_valid=1 in GNT_B: y_valid=0 and s=00 immediately; after release with both valid, A is granted first.
REQ-039 A random valid/ready soak of 10k cycles: the output sequence equals the per-source input order, with no loss, no duplication and no simultaneous a_ready/b_ready.
